// File: rtl/hready_wait_ctrl.sv
// hready_wait_ctrl: AHB-Lite data-phase controller. Each address region has a
// fixed wait count, an optional external-ready hold with timeout and an
// optional ERROR response. Outputs are decoded from the state register only.
module hready_wait_ctrl #(
   parameter int ADDR_W      = 8,
   parameter int NUM_REGIONS = 4,
   parameter int REGION_LSB  = 4,
   parameter int WAIT_W      = 4,
   parameter int TIMEOUT     = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            hsel,
   input  logic [1:0]                      htrans,
   input  logic                            hwrite,
   input  logic [ADDR_W-1:0]               haddr,
   input  logic                            hready,
   input  logic [NUM_REGIONS*WAIT_W-1:0]   region_wait,
   input  logic [NUM_REGIONS-1:0]          region_ext,
   input  logic [NUM_REGIONS-1:0]          region_err,
   input  logic [NUM_REGIONS-1:0]          ext_ready,
   output logic                            hreadyout,
   output logic                            hresp,
   output logic                            data_phase,
   output logic [$clog2(NUM_REGIONS)-1:0]  xfer_region,
   output logic                            xfer_write,
   output logic                            xfer_done
);

   localparam int RIDX_W = $clog2(NUM_REGIONS);
   localparam int TCNT_W = $clog2(TIMEOUT + 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_EXTW,
      S_DONE,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t              state, state_nxt;
   logic [WAIT_W-1:0]   wcnt, wcnt_nxt;
   logic [TCNT_W-1:0]   tcnt, tcnt_nxt;
   logic                xfer_ext;
   logic                acc_req;
   logic                start;
   logic [RIDX_W-1:0]   acc_region;
   logic [WAIT_W-1:0]   acc_wait;
   logic                acc_ext;
   logic                acc_err;
   logic                unused_inputs;

   // Timeout counter increment that sticks at its top value.
   function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
      if (v == {TCNT_W{1'b1}})
         return v;
      return v + TCNT_W'(1);
   endfunction

   assign acc_req       = hsel & htrans[1] & hready;
   assign acc_region    = haddr[REGION_LSB +: RIDX_W];
   assign acc_ext       = region_ext[acc_region];
   assign acc_err       = region_err[acc_region];
   assign unused_inputs = ^{htrans[0], haddr};

   // A new transfer is only taken while the previous data phase is completing.
   assign start = acc_req & hreadyout;

   // Select the wait count of the region addressed by the incoming transfer.
   always_comb begin
      acc_wait = '0;
      for (int r = 0; r < NUM_REGIONS; r++) begin
         if (acc_region == r[RIDX_W-1:0])
            acc_wait = region_wait[r*WAIT_W +: WAIT_W];
      end
   end

   // Next-state and counter logic; the timeout counter is zero outside EXTW.
   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      tcnt_nxt  = '0;
      case (state)
         S_IDLE, S_DONE, S_ERR2: begin
            state_nxt = S_IDLE;
            if (acc_req) begin
               if (acc_err) begin
                  state_nxt = S_ERR1;
               end else if (acc_wait != '0) begin
                  state_nxt = S_WAIT;
                  wcnt_nxt  = acc_wait;
               end else if (acc_ext) begin
                  state_nxt = S_EXTW;
               end else begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_WAIT: begin
            wcnt_nxt = wcnt - WAIT_W'(1);
            if (wcnt == WAIT_W'(1))
               state_nxt = xfer_ext ? S_EXTW : S_DONE;
         end
         S_EXTW: begin
            tcnt_nxt = sat_inc(tcnt);
            if (ext_ready[xfer_region]) begin
               state_nxt = S_DONE;
            end else if (tcnt >= TCNT_LAST) begin
               state_nxt = S_ERR1;
            end
         end
         S_ERR1: begin
            state_nxt = S_ERR2;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State, counters and latched transfer attributes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         wcnt        <= '0;
         tcnt        <= '0;
         xfer_region <= '0;
         xfer_write  <= 1'b0;
         xfer_ext    <= 1'b0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         tcnt  <= tcnt_nxt;
         if (start) begin
            xfer_region <= acc_region;
            xfer_write  <= hwrite;
            xfer_ext    <= acc_ext;
         end
      end
   end

   assign hreadyout  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);
   assign hresp      = (state == S_ERR1) || (state == S_ERR2);
   assign data_phase = (state != S_IDLE);
   assign xfer_done  = (state == S_DONE);

endmodule

// File: tb/tb_hready_wait_ctrl.sv
// Testbench for hready_wait_ctrl: a vector table, hand-written multi-cycle
// sequences, and randomized traffic against a timing-based reference model.
module tb_hready_wait_ctrl;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst, hsel, hwrite, hready;
   logic [1:0]  htrans;
   logic [7:0]  haddr;
   logic [15:0] region_wait;
   logic [3:0]  region_ext, region_err, ext_ready;
   logic        hreadyout, hresp, data_phase, xfer_write, xfer_done;
   logic [1:0]  xfer_region;
   logic [6:0]  outs;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model state: one transfer described by its start cycle,
   // latched configuration and the cycle ext_ready was first seen high.
   logic        m_active, m_ext, m_err, m_wr;
   logic [1:0]  m_reg;
   int          m_t0, m_n, m_found;
   int          cyc;

   typedef struct {
      int         rst;
      int         sel;
      int         trans;
      int         wr;
      int         addr;
      int         hrdy;
      int         erdy;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   assign outs = {hreadyout, hresp, data_phase, xfer_region, xfer_write, xfer_done};

   hready_wait_ctrl #(
      .ADDR_W(8), .NUM_REGIONS(4), .REGION_LSB(4), .WAIT_W(4), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
      .haddr(haddr), .hready(hready), .region_wait(region_wait),
      .region_ext(region_ext), .region_err(region_err), .ext_ready(ext_ready),
      .hreadyout(hreadyout), .hresp(hresp), .data_phase(data_phase),
      .xfer_region(xfer_region), .xfer_write(xfer_write), .xfer_done(xfer_done)
   );

   // Expected output vector {rdy, resp, data_phase, region[1:0], write, done}.
   function automatic logic [6:0] E(int r, int p, int d, int g, int w, int n);
      return {1'(r), 1'(p), 1'(d), 2'(g), 1'(w), 1'(n)};
   endfunction

   function automatic vec_t v(int r, int s, int t, int w, int a, int h, int e, logic [6:0] x);
      vec_t tmp;
      tmp.rst = r; tmp.sel = s; tmp.trans = t; tmp.wr = w;
      tmp.addr = a; tmp.hrdy = h; tmp.erdy = e; tmp.exp = x;
      return tmp;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int r, int s, int t, int w, int a, int h, int e);
      rst       = 1'(r);
      hsel      = 1'(s);
      htrans    = 2'(t);
      hwrite    = 1'(w);
      haddr     = 8'(a);
      hready    = 1'(h);
      ext_ready = 4'(e);
   endtask

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s (t=%0t): got %b want %b  [rdy resp dp reg1 reg0 wr done]",
                  name, $time, act, exp);
   endtask

   // Expected outputs in cycle c, derived from elapsed time since acceptance.
   function automatic logic [6:0] model_out(int c);
      int   e;
      logic r, p, dn;
      if (!m_active)
         return {1'b1, 1'b0, 1'b0, m_reg, m_wr, 1'b0};
      e  = c - m_t0;
      r  = 1'b0;
      p  = 1'b0;
      dn = 1'b0;
      if (m_err) begin
         p = 1'b1;
         r = (e >= 2);
      end else if (e <= m_n) begin
         r = 1'b0;
      end else if (!m_ext) begin
         r = 1'b1; dn = 1'b1;
      end else if (m_found >= 0) begin
         if (e > m_found - m_t0) begin
            r = 1'b1; dn = 1'b1;
         end
      end else if (e == m_n + TIMEOUT + 1) begin
         p = 1'b1;
      end else if (e == m_n + TIMEOUT + 2) begin
         r = 1'b1; p = 1'b1;
      end
      return {r, p, 1'b1, m_reg, m_wr, dn};
   endfunction

   initial begin
      logic [6:0] cur;
      logic       acc;
      int         e, rr;

      region_wait = 16'h0130;   // r0=0, r1=3, r2=1, r3=0
      region_ext  = 4'b0100;    // r2 waits for ext_ready
      region_err  = 4'b1000;    // r3 errors
      drive(1, 0, 0, 0, 0, 1, 0);
      tick();
      tick();

      // Vector table: inputs during a cycle, outputs expected in the next.
      tbl.push_back(v(1, 0, 0, 0, 8'h00, 1, 0, E(1,0,0,0,0,0)));
      tbl.push_back(v(0, 1, 2, 0, 8'h00, 1, 0, E(1,0,1,0,0,1)));
      tbl.push_back(v(0, 1, 2, 0, 8'h04, 1, 0, E(1,0,1,0,0,1)));
      tbl.push_back(v(0, 1, 2, 0, 8'h08, 1, 0, E(1,0,1,0,0,1)));
      tbl.push_back(v(0, 1, 0, 0, 8'h00, 1, 0, E(1,0,0,0,0,0)));
      tbl.push_back(v(0, 1, 1, 1, 8'h10, 1, 0, E(1,0,0,0,0,0)));
      tbl.push_back(v(0, 1, 2, 1, 8'h10, 1, 0, E(0,0,1,1,1,0)));
      tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 0, E(0,0,1,1,1,0)));
      tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 0, E(0,0,1,1,1,0)));
      tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 0, E(1,0,1,1,1,1)));
      tbl.push_back(v(0, 1, 2, 0, 8'h30, 1, 0, E(0,1,1,3,0,0)));
      tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 0, E(1,1,1,3,0,0)));
      tbl.push_back(v(0, 1, 2, 0, 8'h00, 1, 0, E(1,0,1,0,0,1)));
      tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 0, E(1,0,0,0,0,0)));
      tbl.push_back(v(0, 0, 2, 1, 8'h10, 1, 0, E(1,0,0,0,0,0)));
      tbl.push_back(v(0, 1, 2, 1, 8'h10, 0, 0, E(1,0,0,0,0,0)));
      tbl.push_back(v(0, 1, 3, 0, 8'h20, 1, 0, E(0,0,1,2,0,0)));
      tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 4, E(0,0,1,2,0,0)));
      tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 4, E(1,0,1,2,0,1)));
      tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 0, E(1,0,0,2,0,0)));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].sel, tbl[i].trans, tbl[i].wr,
               tbl[i].addr, tbl[i].hrdy, tbl[i].erdy);
         tick();
         chk($sformatf("vec%0d", i), outs, tbl[i].exp);
      end

      // External hold: region 2, wait 1, ext_ready[2] rises in cycle 5.
      drive(0, 1, 2, 0, 8'h20, 1, 0);
      tick();
      chk("ext_c1", outs, E(0,0,1,2,0,0));
      for (int c = 1; c <= 5; c++) begin
         drive(0, 0, 0, 0, 8'h00, 1, (c == 5) ? 4'b0100 : 4'b1011);
         tick();
         chk($sformatf("ext_c%0d", c + 1), outs,
             (c == 5) ? E(1,0,1,2,0,1) : E(0,0,1,2,0,0));
      end
      drive(0, 0, 0, 0, 8'h00, 1, 0);
      tick();
      chk("ext_idle", outs, E(1,0,0,2,0,0));

      // Timeout: ext_ready[2] held low; config changes after accept are ignored.
      drive(0, 1, 2, 1, 8'h20, 1, 4'b1011);
      tick();
      drive(0, 0, 0, 0, 8'h00, 1, 4'b1011);
      region_ext        = 4'b0000;
      region_wait[11:8] = 4'd0;
      for (int k = 1; k <= 20; k++) begin
         chk($sformatf("tmo_c%0d", k), outs,
             (k <= 17) ? E(0,0,1,2,1,0) :
             (k == 18) ? E(0,1,1,2,1,0) :
             (k == 19) ? E(1,1,1,2,1,0) : E(1,0,0,2,1,0));
         tick();
      end
      region_ext  = 4'b0100;
      region_wait = 16'h0130;

      // Reset mid-wait: region 1 with wait 15, rst asserted in cycle 4.
      region_wait = 16'h01F0;
      drive(0, 1, 2, 0, 8'h10, 1, 0);
      tick();
      drive(0, 0, 0, 0, 8'h00, 1, 0);
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("rst_c%0d", k), outs, E(0,0,1,1,0,0));
         if (k == 4)
            rst = 1'b1;
         tick();
      end
      chk("rst_idle", outs, E(1,0,0,0,0,0));
      drive(0, 1, 2, 1, 8'h00, 1, 0);
      tick();
      chk("rst_after_xfer", outs, E(1,0,1,0,1,1));
      drive(0, 0, 0, 0, 8'h00, 1, 0);
      tick();
      chk("rst_after_idle", outs, E(1,0,0,0,1,0));
      region_wait = 16'h0130;

      // Randomized traffic against the reference model.
      drive(1, 0, 0, 0, 8'h00, 1, 0);
      tick();
      m_active = 1'b0; m_reg = 2'd0; m_wr = 1'b0;
      m_ext = 1'b0; m_err = 1'b0; m_t0 = 0; m_n = 0; m_found = -1;
      cyc = 0;
      chk("rand_reset", outs, model_out(cyc));
      for (int it = 0; it < 4000; it++) begin
         rst    = ($urandom_range(0, 99) == 0);
         hsel   = ($urandom_range(0, 3) != 0);
         htrans = 2'($urandom_range(0, 3));
         hwrite = 1'($urandom_range(0, 1));
         haddr  = 8'($urandom);
         hready = ($urandom_range(0, 7) != 0);
         for (int r = 0; r < 4; r++) begin
            region_wait[r*4 +: 4] = ($urandom_range(0, 7) == 0) ?
                                    4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            region_ext[r] = 1'($urandom_range(0, 1));
            region_err[r] = ($urandom_range(0, 7) == 0);
            ext_ready[r]  = ($urandom_range(0, 5) == 0);
         end

         cur = model_out(cyc);
         acc = hsel & htrans[1] & hready;
         if (rst) begin
            m_active = 1'b0;
            m_reg    = 2'd0;
            m_wr     = 1'b0;
         end else begin
            if (m_active && m_ext && !m_err && m_found < 0) begin
               e = cyc - m_t0;
               if (e >= m_n + 1 && e <= m_n + TIMEOUT && ext_ready[m_reg])
                  m_found = cyc;
            end
            if (cur[6] && acc) begin
               rr       = int'(haddr[5:4]);
               m_active = 1'b1;
               m_t0     = cyc;
               m_reg    = haddr[5:4];
               m_wr     = hwrite;
               m_err    = region_err[rr];
               m_ext    = region_ext[rr];
               m_n      = int'(region_wait[rr*4 +: 4]);
               m_found  = -1;
            end else if (m_active && cur[6]) begin
               m_active = 1'b0;
            end
         end
         tick();
         cyc++;
         chk("random", outs, model_out(cyc));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/hready_wait_ctrl.md
# hready_wait_ctrl

Parametrised AHB-Lite data-phase controller for the USB subordinate. It drives HREADYOUT and HRESP for every transfer addressed to the block. Each of NUM_REGIONS address regions is configured with a fixed wait-state count, an optional external-ready hold with timeout, and an optional error response. It generalises the single-region hready controller, and the register and FIFO back-ends use it to stall the bus until their data is valid.

## Interface
Parameters:
- ADDR_W, 8, width of haddr.
- NUM_REGIONS, 4, number of address regions (power of two, ≥2).
- REGION_LSB, 4, lowest haddr bit of the region index; index = haddr[REGION_LSB +: $clog2(NUM_REGIONS)].
- WAIT_W, 4, width of each per-region wait count.
- TIMEOUT, 16, maximum external-ready cycles before an error response (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- hsel  in  1  subordinate select.
- htrans  in  2  AHB transfer type.
- hwrite  in  1  transfer direction.
- haddr  in  ADDR_W  transfer address.
- hready  in  1  bus-level HREADY.
- region_wait  in  NUM_REGIONS*WAIT_W  wait count per region, region r at [r*WAIT_W +: WAIT_W].
- region_ext  in  NUM_REGIONS  1 = region also waits for ext_ready after its wait count.
- region_err  in  NUM_REGIONS  1 = region returns an ERROR response.
- ext_ready  in  NUM_REGIONS  per-region back-end ready.
- hreadyout  out  1  subordinate HREADYOUT.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- data_phase  out  1  high while an accepted transfer is in its data phase.
- xfer_region  out  $clog2(NUM_REGIONS)  region of the current data phase.
- xfer_write  out  1  hwrite of the current data phase.
- xfer_done  out  1  one-cycle pulse on an OKAY completion cycle.

## Operation
- Accept condition: hsel & htrans[1] & hready. The region index, the region's config bits, and hwrite are latched on the accepting edge. IDLE and BUSY transfers are never accepted.
- FSM states:
  - IDLE: hreadyout=1, hresp=0.
  - WAIT: hreadyout=0. The counter is loaded with region_wait and decrements once per cycle.
  - EXTW: hreadyout=0. The block waits for ext_ready[xfer_region].
  - DONE: hreadyout=1, hresp=0.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
- On accept, the next state is chosen in this priority order:
  - region_err → ERR1.
  - region_wait ≠ 0 → WAIT.
  - region_ext → EXTW.
  - otherwise → DONE.
- WAIT: when the counter equals 1, the next state is EXTW if region_ext, else DONE.
- EXTW: ext_ready sampled high → DONE. After TIMEOUT consecutive cycles without ext_ready → ERR1.
- Unconditional transitions: ERR1 → ERR2.
- From DONE or ERR2:
  - accept → evaluate the new transfer as above (back-to-back pipelining).
  - no accept → IDLE.
- IDLE: accept → evaluate; otherwise stay in IDLE.
- Region configuration is sampled only on the accepting edge. Changes mid-transfer have no effect until the next transfer.
- data_phase=1 in WAIT, EXTW, DONE, ERR1, and ERR2.
- xfer_done=1 only in DONE.

## Timing
- Reset state: IDLE, hreadyout=1, hresp=0, data_phase=0, xfer_region=0, xfer_write=0, xfer_done=0, all counters 0.
- rst asserted in any state forces IDLE on the next edge. Any in-flight transfer is abandoned with no ERROR and no xfer_done.
- Latency, with the accepting edge as cycle 0:
  - Wait count N, no ext: hreadyout=0 in cycles 1..N; completion in cycle N+1.
  - Ext enabled, ext_ready first sampled high in cycle N+k: completion in cycle N+k+1.
  - Timeout: ERR1 in cycle N+TIMEOUT+1, ERR2 in cycle N+TIMEOUT+2.
  - Error region: ERR1 in cycle 1, ERR2 in cycle 2.
- ext_ready already high in the first EXTW cycle → DONE next cycle, costing one extra cycle beyond N.
- The timeout counter clears on entry to EXTW and saturates. Its width is $clog2(TIMEOUT+1).
- All outputs are registered state decodes, with no combinational path from inputs to hreadyout or hresp.

## Test plan
- Zero-wait back-to-back: region 0, wait=0, no ext. NONSEQ reads on 3 consecutive cycles → hreadyout stays 1 and xfer_done pulses in cycles 1, 2, 3 with xfer_region=0.
- Fixed waits: region 1, wait=3. One NONSEQ write → hreadyout=0 in cycles 1–3, DONE in cycle 4, xfer_write=1, xfer_region=1.
- External hold: region 2, wait=1, ext=1; ext_ready rises in cycle 5 → hreadyout low in cycles 1–5, DONE in cycle 6.
- Timeout: region 2, TIMEOUT=16, ext_ready held low → ERR1 in cycle 18 (hreadyout=0, hresp=1), then ERR2 in cycle 19 (hreadyout=1, hresp=1), then IDLE, with no xfer_done.
- Error region with pipelined follow-up: region 3 err=1, then a region 0 transfer issued during ERR2 → two-cycle ERROR, then the region 0 transfer completes OKAY one cycle later.
- Reset mid-wait: region 1, wait=15, rst asserted in cycle 4 → next cycle IDLE, hreadyout=1, hresp=0, data_phase=0. A new transfer after reset completes normally.
